// File: rtl/mic_note_pkg.sv
// Shared constants for the microphone note detector and the piano tone generator:
// one-hot note codes, period bin boundaries and the reader FSM state encoding.
package mic_note_pkg;

  localparam logic [9:0] NOTE_C4 = 10'b00_0000_0001;
  localparam logic [9:0] NOTE_D4 = 10'b00_0000_0010;
  localparam logic [9:0] NOTE_E4 = 10'b00_0000_0100;
  localparam logic [9:0] NOTE_F4 = 10'b00_0000_1000;
  localparam logic [9:0] NOTE_G4 = 10'b00_0001_0000;
  localparam logic [9:0] NOTE_A4 = 10'b00_0010_0000;
  localparam logic [9:0] NOTE_B4 = 10'b00_0100_0000;
  localparam logic [9:0] NOTE_C5 = 10'b00_1000_0000;
  localparam logic [9:0] NOTE_D5 = 10'b01_0000_0000;
  localparam logic [9:0] NOTE_E5 = 10'b10_0000_0000;

  // Lowest averaged period (in samples) that still maps to each note.
  localparam logic [10:0] C4_MIN = 11'd173;
  localparam logic [10:0] D4_MIN = 11'd155;
  localparam logic [10:0] E4_MIN = 11'd141;
  localparam logic [10:0] F4_MIN = 11'd130;
  localparam logic [10:0] G4_MIN = 11'd116;
  localparam logic [10:0] A4_MIN = 11'd103;
  localparam logic [10:0] B4_MIN = 11'd94;
  localparam logic [10:0] C5_MIN = 11'd87;
  localparam logic [10:0] D5_MIN = 11'd77;

  localparam logic [10:0] MIN_PERIOD = 11'd66;
  localparam logic [10:0] MAX_PERIOD = 11'd195;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_PROC = 2'd2;

  // Magnitude of a signed sample; -32768 saturates to 32767.
  function automatic logic [15:0] abs_sat(input logic [15:0] v);
    if (!v[15]) begin
      return v;
    end else if (v == 16'h8000) begin
      return 16'h7fff;
    end else begin
      return (~v) + 16'd1;
    end
  endfunction

endpackage

// File: rtl/note_bin_lookup.sv
// Maps an averaged tone period (in samples) to the one-hot piano note it falls in.
// Purely combinational; periods outside every bin give 0.
module note_bin_lookup (
  input  logic [10:0] avg,
  output logic [9:0]  onehot
);
  import mic_note_pkg::*;

  always_comb begin
    onehot = 10'd0;
    if (avg < MIN_PERIOD || avg > MAX_PERIOD) begin
      onehot = 10'd0;
    end else if (avg >= C4_MIN) begin
      onehot = NOTE_C4;
    end else if (avg >= D4_MIN) begin
      onehot = NOTE_D4;
    end else if (avg >= E4_MIN) begin
      onehot = NOTE_E4;
    end else if (avg >= F4_MIN) begin
      onehot = NOTE_F4;
    end else if (avg >= G4_MIN) begin
      onehot = NOTE_G4;
    end else if (avg >= A4_MIN) begin
      onehot = NOTE_A4;
    end else if (avg >= B4_MIN) begin
      onehot = NOTE_B4;
    end else if (avg >= C5_MIN) begin
      onehot = NOTE_C5;
    end else if (avg >= D5_MIN) begin
      onehot = NOTE_D5;
    end else begin
      onehot = NOTE_E5;
    end
  end

endmodule

// File: rtl/mic_note_detector.sv
// Detects the piano note on the left ADC channel from hysteresis zero-crossing periods.
// Define LEVEL_METER_EN to add the per-window peak level output.
module mic_note_detector #(
  parameter logic [15:0] THRESH     = 16'd512,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned MIN_PERIOD = 66,
  parameter int unsigned MAX_PERIOD = 195
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  output logic        read_audio_in,
  output logic [9:0]  note_onehot,
  output logic        note_valid,
  output logic [10:0] period_avg,
  output logic [15:0] level
);
  import mic_note_pkg::*;

  localparam logic [10:0] MinP     = 11'(MIN_PERIOD);
  localparam logic [10:0] MaxP     = 11'(MAX_PERIOD);
  localparam logic [10:0] TimeoutC = 11'(TIMEOUT);
  localparam logic [AVG_LOG2-1:0] NperOne = AVG_LOG2'(1);

  logic [1:0]          state_q, state_d;
  logic [15:0]         s_q;
  logic                pol_q, pol_d;
  logic                armed_q, armed_d;
  logic [10:0]         count_q, count_d;
  logic [12:0]         sum_q, sum_d;
  logic [AVG_LOG2-1:0] nper_q, nper_d;
  logic [10:0]         period_q, period_d;
  logic [9:0]          note_q, note_d;

  logic signed [16:0] s_ext, thr_pos, thr_neg;
  logic        proc, above, below, rise, in_range, timeout;
  logic        evt_register, evt_drop, evt_timeout;
  logic [12:0] sum_acc;
  logic [10:0] avg;
  logic [9:0]  bin_onehot;
  logic        unused_lo;

  assign unused_lo = ^left_channel_audio_in[15:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (audio_in_available) state_d = ST_READ;
      ST_READ: state_d = ST_PROC;
      ST_PROC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign read_audio_in = (state_q == ST_READ);
  assign proc          = (state_q == ST_PROC);

  assign s_ext   = {s_q[15], s_q};
  assign thr_pos = {1'b0, THRESH};
  assign thr_neg = -thr_pos;
  assign above   = s_ext > thr_pos;
  assign below   = s_ext < thr_neg;
  assign rise    = !pol_q && above;

  // count_q holds the samples elapsed since the last rise, i.e. the period on a rise.
  assign in_range = (count_q >= MinP) && (count_q <= MaxP);
  assign timeout  = !rise && (count_q >= TimeoutC);
  assign sum_acc  = sum_q + {2'b00, count_q};
  assign avg      = 11'(sum_acc >> AVG_LOG2);

  assign evt_register = proc && rise && armed_q && in_range && (&nper_q);
  assign evt_drop     = proc && rise && armed_q && !in_range;
  assign evt_timeout  = proc && timeout;

  note_bin_lookup u_bin (
    .avg    (avg),
    .onehot (bin_onehot)
  );

  always_comb begin
    pol_d    = pol_q;
    armed_d  = armed_q;
    count_d  = count_q;
    sum_d    = sum_q;
    nper_d   = nper_q;
    period_d = period_q;
    note_d   = note_q;
    if (proc) begin
      pol_d   = pol_q ? !below : above;
      count_d = rise ? 11'd1 : (count_q >= TimeoutC ? count_q : count_q + 11'd1);
      if (rise) begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (evt_register) begin
          period_d = avg;
          note_d   = bin_onehot;
          sum_d    = '0;
          nper_d   = '0;
        end else if (in_range) begin
          sum_d  = sum_acc;
          nper_d = nper_q + NperOne;
        end else begin
          sum_d  = '0;
          nper_d = '0;
        end
      end else if (timeout) begin
        note_d  = '0;
        armed_d = 1'b0;
        sum_d   = '0;
        nper_d  = '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      pol_q    <= 1'b0;
      armed_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      nper_q   <= '0;
      period_q <= '0;
      note_q   <= '0;
    end else begin
      state_q  <= state_d;
      if (read_audio_in) s_q <= left_channel_audio_in[31:16];
      pol_q    <= pol_d;
      armed_q  <= armed_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      nper_q   <= nper_d;
      period_q <= period_d;
      note_q   <= note_d;
    end
  end

  assign note_onehot = note_q;
  assign note_valid  = |note_q;
  assign period_avg  = period_q;

`ifdef LEVEL_METER_EN
  logic [15:0] peak_q, peak_d, level_q, level_d, mag, peak_max;

  assign mag      = abs_sat(s_q);
  assign peak_max = (mag > peak_q) ? mag : peak_q;

  // The window restarts whenever the accumulated periods are published or discarded.
  always_comb begin
    peak_d  = peak_q;
    level_d = level_q;
    if (proc) peak_d = peak_max;
    if (evt_register) begin
      level_d = peak_max;
      peak_d  = '0;
    end
    if (evt_drop) peak_d = '0;
    if (evt_timeout) begin
      level_d = '0;
      peak_d  = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      peak_q  <= '0;
      level_q <= '0;
    end else begin
      peak_q  <= peak_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  assign level = 16'd0;
`endif

endmodule

// File: tb/tb_mic_note_detector.sv
// Directed bench for mic_note_detector: sample-level reference model checked every cycle,
// plus literal expectations for handshake, detection, hysteresis, timeout, range and reset.
module tb_mic_note_detector;

  logic        clk = 1'b0;
  logic        resetn;
  logic        avail;
  logic [31:0] left_in;
  logic        read_audio_in;
  logic [9:0]  note_onehot;
  logic        note_valid;
  logic [10:0] period_avg;
  logic [15:0] level;

  mic_note_detector dut (
    .CLOCK_50              (clk),
    .resetn                (resetn),
    .audio_in_available    (avail),
    .left_channel_audio_in (left_in),
    .read_audio_in         (read_audio_in),
    .note_onehot           (note_onehot),
    .note_valid            (note_valid),
    .period_avg            (period_avg),
    .level                 (level)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: works on whole samples and lists of measured periods.
  bit        m_pol, m_armed;
  int        m_since, m_peak, rise_total;
  int        m_q[$];
  logic [9:0] exp_note;
  int        exp_avg, exp_level;
  int        ph;
  bit        got;

  int bin_lo[10] = '{173, 155, 141, 130, 116, 103, 94, 87, 77, 66};
  int bin_hi[10] = '{195, 172, 154, 140, 129, 115, 102, 93, 86, 76};

  function automatic logic [9:0] bin_of(input int a);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) if (a >= bin_lo[i] && a <= bin_hi[i]) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int level_exp();
`ifdef LEVEL_METER_EN
    return exp_level;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_pol = 0; m_armed = 0; m_since = 0; m_peak = 0;
    m_q.delete();
    exp_note = '0; exp_avg = 0; exp_level = 0;
  endtask

  task automatic model_step(input logic signed [15:0] v);
    int vi, a, period, sum;
    bit rise;
    vi = v;
    a = (vi < 0) ? ((vi == -32768) ? 32767 : -vi) : vi;
    if (a > m_peak) m_peak = a;
    rise = !m_pol && vi > 512;
    if (rise) m_pol = 1;
    else if (m_pol && vi < -512) m_pol = 0;
    period = m_since;
    if (rise) begin
      rise_total++;
      m_since = 1;
      if (!m_armed) begin
        m_armed = 1;
      end else if (period >= 66 && period <= 195) begin
        m_q.push_back(period);
        if (m_q.size() == 4) begin
          sum = 0;
          foreach (m_q[i]) sum += m_q[i];
          exp_avg   = sum / 4;
          exp_note  = bin_of(exp_avg);
          exp_level = m_peak;
          m_peak    = 0;
          m_q.delete();
        end
      end else begin
        m_q.delete();
        m_peak = 0;
      end
    end else begin
      if (m_since >= 1024) begin
        exp_note = '0; m_armed = 0; m_q.delete(); m_peak = 0; exp_level = 0;
      end
      m_since++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("note_onehot", int'(note_onehot), int'(exp_note));
      chk("note_valid", int'(note_valid), int'(exp_note != 0));
      chk("period_avg", int'(period_avg), exp_avg);
      chk("level", int'(level), level_exp());
    end
  end

  // One handshake: wait for the strobe, check it is one cycle wide, then step the model
  // on the edge where the DUT registers its outputs.
  task automatic feed(input logic signed [15:0] v);
    bit g;
    g = 0;
    left_in = {v, 16'h5a5a};
    avail = 1'b1;
    for (int k = 0; k < 8 && !g; k++) begin
      @(negedge clk);
      if (read_audio_in) g = 1;
    end
    avail = 1'b0;
    chk("read_strobe", int'(g), 1);
    if (g) begin
      @(posedge clk);
      @(negedge clk);
      chk("read_width", int'(read_audio_in), 0);
      @(posedge clk);
      model_step(v);
    end
  endtask

  function automatic logic signed [15:0] wave_v(input int period, input int p);
    return (p < (period + 1) / 2) ? 16'sd20000 : -16'sd20000;
  endfunction

  task automatic run_wave(input int period, input int n);
    int target, limit;
    target = rise_total + n;
    limit  = (n + 1) * period + 4;
    for (int i = 0; i < limit && rise_total < target; i++) begin
      feed(wave_v(period, ph));
      ph = (ph + 1) % period;
    end
  endtask

  initial begin
    int pulses;
    logic signed [15:0] sv;
    resetn = 1'b0; avail = 1'b0; left_in = '0; rise_total = 0; ph = 0;
    model_reset();
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_note", int'(note_onehot), 0);
    chk("rst_valid", int'(note_valid), 0);
    chk("rst_period", int'(period_avg), 0);
    chk("rst_read", int'(read_audio_in), 0);
    chk("rst_level", int'(level), 0);
    resetn = 1'b1;

    // Handshake: 30 cycles of available -> strobe on every 3rd cycle.
    @(negedge clk);
    left_in = '0; avail = 1'b1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("read_phase", int'(read_audio_in), int'(i % 3 == 0));
      if (read_audio_in) pulses++;
    end
    avail = 1'b0;
    chk("read_pulses", pulses, 10);
    for (int i = 0; i < 10; i++) model_step(16'sd0);
    @(negedge clk);

    // Hysteresis: small sine never crosses.
    for (int i = 0; i < 2000; i++) begin
      sv = 16'($rtoi(300.0 * $sin(6.283185307179586 * i / 109.0)));
      feed(sv);
    end
    @(negedge clk);
    chk("hyst_note", int'(note_onehot), 0);

    // Detection: period 109 -> A4 after the 5th rise.
    ph = 0;
    run_wave(109, 4);
    @(negedge clk);
    chk("detect_pre_valid", int'(note_valid), 0);
    run_wave(109, 1);
    @(negedge clk);
    chk("detect_note", int'(note_onehot), 32);
    chk("detect_valid", int'(note_valid), 1);
    chk("detect_period", int'(period_avg), 109);

    // Timeout: E5, then a constant high input.
    ph = 0;
    run_wave(73, 10);
    @(negedge clk);
    chk("e5_note", int'(note_onehot), 512);
    chk("e5_period", int'(period_avg), 73);
    for (int i = 0; i < 1023; i++) feed(16'sd20000);
    @(negedge clk);
    chk("to_hold_note", int'(note_onehot), 512);
    feed(16'sd20000);
    @(negedge clk);
    chk("to_note", int'(note_onehot), 0);
    chk("to_valid", int'(note_valid), 0);
    chk("to_period_hold", int'(period_avg), 73);

    // Out of range period 50, then C4.
    ph = 0;
    run_wave(50, 20);
    @(negedge clk);
    chk("oor_valid", int'(note_valid), 0);
    ph = 0;
    run_wave(183, 5);
    @(negedge clk);
    chk("c4_note", int'(note_onehot), 1);
    chk("c4_period", int'(period_avg), 183);

    // Reset in the middle of a handshake, then a fresh note.
    ph = 0;
    run_wave(109, 2);
    left_in = {wave_v(109, ph), 16'h0};
    avail = 1'b1; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (read_audio_in) got = 1;
    end
    chk("abort_strobe", int'(got), 1);
    #1 resetn = 1'b0;
    avail = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_note", int'(note_onehot), 0);
    chk("abort_period", int'(period_avg), 0);
    #1 resetn = 1'b1;
    ph = 0;
    run_wave(109, 4);
    @(negedge clk);
    chk("fresh4_valid", int'(note_valid), 0);
    run_wave(109, 1);
    @(negedge clk);
    chk("fresh5_note", int'(note_onehot), 32);
    chk("fresh5_period", int'(period_avg), 109);
`ifdef LEVEL_METER_EN
    chk("fresh5_level", int'(level), 20000);
`else
    chk("fresh5_level", int'(level), 0);
`endif

    chk_en = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mic_note_detector.md
Name: mic_note_detector

Overview:
- Audio-input counterpart of the piano tone generator. Consumes left-channel ADC samples from Audio_Controller through the audio_in_available / read_audio_in handshake.
- Measures the period of the incoming tone using zero crossings with hysteresis, averaged over several periods.
- Reports which of the ten piano notes (C4..E5) is being played, using the same one-hot encoding as the piano's SW selection.
- Sits beside the tone generator at top level; drives only read_audio_in on the controller.

Parameters:
- THRESH, 16'd512, hysteresis magnitude applied to the upper 16 bits of each sample.
- AVG_LOG2, 2, log2 of the number of periods averaged (4 periods).
- TIMEOUT, 1024, samples without a rising crossing before the note is cleared.
- MIN_PERIOD, 66, smallest accepted period in samples.
- MAX_PERIOD, 195, largest accepted period in samples.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- audio_in_available  in  1  controller has an ADC sample pending.
- left_channel_audio_in  in  32  signed sample; bits [31:16] are used.
- read_audio_in  out  1  one-cycle pop strobe to the controller.
- note_onehot  out  10  bit0 = C4, bit1 = D4, ... bit9 = E5; 0 = no note.
- note_valid  out  1  high while note_onehot is nonzero.
- period_avg  out  11  last accepted averaged period, in samples.
- level  out  16  peak magnitude (see Optional Feature).

Behaviour:
- Reset: the asynchronous assertion of resetn clears every output to 0. Internal state after reset:
  - FSM = IDLE, polarity = NEG, armed = 0
  - count = 0, sum = 0, nper = 0
- FSM states: IDLE -> READ -> PROC -> IDLE.
  - IDLE: move to READ when audio_in_available = 1.
  - READ: read_audio_in = 1 for exactly this cycle. s = left_channel_audio_in[31:16] is latched in the same cycle.
  - PROC: process s as described below, then return to IDLE.
- Throughput: at most one read every 3 cycles. read_audio_in is decoded from registered state and is never high outside READ.
- Hysteresis comparator, evaluated in PROC on signed s:
  - polarity NEG -> POS when s > +THRESH.
  - polarity POS -> NEG when s < -THRESH.
  - Values in [-THRESH, +THRESH] hold the current polarity.
  - rise = transition from NEG to POS.
- Period counter:
  - count = count + 1 on each processed sample, saturating at TIMEOUT.
  - On rise, count reloads to 1.
- On rise, with armed = 0:
  - Set armed = 1.
  - Do not accumulate.
- On rise, with armed = 1 and MIN_PERIOD <= count <= MAX_PERIOD:
  - sum += count (width 13 bits), nper += 1.
  - When nper reaches 2^AVG_LOG2:
    - avg = sum >> AVG_LOG2.
    - Register period_avg = avg.
    - Register note_onehot from the bin lookup; note_valid = |note_onehot.
    - Clear sum and nper.
- On rise, with armed = 1 and count out of range: clear sum and nper, keep armed = 1. Outputs are unchanged.
- Bin lookup (avg range, inclusive -> note):
  - 173-195 C4
  - 155-172 D4
  - 141-154 E4
  - 130-140 F4
  - 116-129 G4
  - 103-115 A4
  - 94-102 B4
  - 87-93 C5
  - 77-86 D5
  - 66-76 E5
  - Anything else -> 0.
- Timeout: when count reaches TIMEOUT with no rise on that sample:
  - note_onehot = 0, note_valid = 0.
  - armed = 0, sum = 0, nper = 0.
  - period_avg holds its value.
  - If rise and the saturation occur on the same sample, rise takes precedence.
- Latency: outputs change on the cycle after PROC, i.e. 2 cycles after the read_audio_in strobe of the deciding sample.
- audio_in_available dropping while the FSM is in READ or PROC has no effect; the current sample is still processed.
- Reset asserted mid-operation aborts the operation immediately; no partial accumulation survives.

Optional Feature:
- Macro: LEVEL_METER_EN.
- Defined:
  - level tracks the peak |s| seen in the current averaging window (the negation of -32768 saturates to 32767).
  - level is registered at the same point as note_onehot; the window peak then clears.
  - On timeout, level is cleared to 0.
- Undefined: level is tied to 16'd0 and no peak logic is synthesised.

Decomposition:
- Shared package mic_note_pkg holds:
  - NOTE_* one-hot constants, shared with the tone generator.
  - The nine bin boundary constants plus MIN_PERIOD and MAX_PERIOD.
  - The FSM state enum.
- One sub-module: note_bin_lookup.
  - Purely combinational: 11-bit avg in, 10-bit one-hot out.
  - Reusable by the tone generator for self-check.

Test Plan:
- Handshake: audio_in_available held high for 30 cycles -> read_audio_in pulses on exactly every 3rd cycle, each pulse one cycle wide, 10 pulses total.
- Note detection: square wave of period 109 samples (55 samples at +20000, 54 at -20000) -> after the 5th rise, note_onehot = 10'd32, note_valid = 1, period_avg = 109.
- Hysteresis: sine with amplitude 300 at period 109 -> no rise; note_onehot stays 0 through 2000 samples.
- Timeout: establish E5 (period 73), then hold +20000 -> note_onehot drops to 0 exactly on processing the 1024th sample after the last rise.
- Out of range: period 50 for 20 periods -> note_valid never asserts. Switching to period 183 -> C4 (10'd1) after 5 further rises.
- Reset: assert resetn = 0 after 2 rises of a 109-sample wave, release, continue the wave -> the note requires 5 fresh rises. With LEVEL_METER_EN defined, level = 20000 once the note is reported.
